// File: rtl/ptcam_scan.sv
// Pseudo-ternary CAM: per-entry valid bits, bit-masked writes, and a masked search
// that scans LANES entries per cycle, reporting the lowest hit, its data and the hit count.
module ptcam_scan #(
   parameter int WIDTH = 19,
   parameter int DEPTH = 16,
   parameter int LANES = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      w_en,
   input  logic [$clog2(DEPTH)-1:0]  w_addr,
   input  logic [WIDTH-1:0]          w_din,
   input  logic [WIDTH-1:0]          w_mask,
   input  logic                      inv_en,
   input  logic [$clog2(DEPTH)-1:0]  inv_addr,
   input  logic                      clr_all,
   input  logic [$clog2(DEPTH)-1:0]  r_addr,
   output logic [WIDTH-1:0]          r_dout,
   output logic                      r_valid,
   input  logic                      search_en,
   input  logic [WIDTH-1:0]          search_din,
   input  logic [WIDTH-1:0]          search_mask,
   output logic                      search_busy,
   output logic                      search_valid,
   output logic [WIDTH-1:0]          search_dout,
   output logic [$clog2(DEPTH)-1:0]  search_addr_out,
   output logic                      search_notfound,
   output logic [$clog2(DEPTH):0]    search_count
);
   localparam int AW   = $clog2(DEPTH);
   localparam int NGRP = DEPTH / LANES;
   localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam int CW   = $clog2(LANES + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] valid_reg;

   logic [WIDTH-1:0] r_dout_reg;
   logic             r_valid_reg;

   logic [1:0]       state_reg;
   logic [GW-1:0]    grp_reg;
   logic [WIDTH-1:0] key_reg, mask_reg;
   logic             found_reg;
   logic [AW-1:0]    faddr_reg;
   logic [WIDTH-1:0] fdata_reg;
   logic [AW:0]      cnt_reg;

   logic             sv_reg, snf_reg;
   logic [WIDTH-1:0] sdout_reg;
   logic [AW-1:0]    saddr_reg;
   logic [AW:0]      scount_reg;

   // An invalidate of the same address overrides the write; clear-all overrides both.
   logic             wr_do;
   logic [WIDTH-1:0] wr_base;
   assign wr_do   = w_en && !reset && !clr_all && !(inv_en && (inv_addr == w_addr));
   assign wr_base = valid_reg[w_addr] ? mem[w_addr] : '0;

   always_ff @(posedge clk) begin
      if (wr_do)
         mem[w_addr] <= (wr_base & ~w_mask) | (w_din & w_mask);
   end

   always_ff @(posedge clk) begin
      if (reset || clr_all) begin
         valid_reg <= '0;
      end else begin
         if (wr_do)
            valid_reg[w_addr] <= 1'b1;
         if (inv_en)
            valid_reg[inv_addr] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dout_reg  <= '0;
         r_valid_reg <= 1'b0;
      end else begin
         r_dout_reg  <= mem[r_addr];
         r_valid_reg <= valid_reg[r_addr];
      end
   end

   // Per-lane compare of the current group against the captured key/mask.
   logic [AW-1:0]    lane_addr [LANES];
   logic [WIDTH-1:0] lane_data [LANES];
   logic [LANES-1:0] lane_hit;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_addr[gi] = AW'(int'(grp_reg) * LANES + gi);
         assign lane_data[gi] = mem[lane_addr[gi]];
         assign lane_hit[gi]  = valid_reg[lane_addr[gi]] &&
                                (((lane_data[gi] ^ key_reg) & mask_reg) == '0);
      end
   endgenerate

   logic             hit_any;
   logic [CW-1:0]    hit_cnt;
   logic [AW-1:0]    hit_addr;
   logic [WIDTH-1:0] hit_data;

   // Walk lanes high to low so the lowest hitting lane is the one left standing.
   always_comb begin
      hit_any  = 1'b0;
      hit_cnt  = '0;
      hit_addr = '0;
      hit_data = '0;
      for (int l = LANES - 1; l >= 0; l--) begin
         if (lane_hit[l]) begin
            hit_any  = 1'b1;
            hit_cnt  = hit_cnt + CW'(1);
            hit_addr = lane_addr[l];
            hit_data = lane_data[l];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         grp_reg    <= '0;
         key_reg    <= '0;
         mask_reg   <= '0;
         found_reg  <= 1'b0;
         faddr_reg  <= '0;
         fdata_reg  <= '0;
         cnt_reg    <= '0;
         sv_reg     <= 1'b0;
         snf_reg    <= 1'b0;
         sdout_reg  <= '0;
         saddr_reg  <= '0;
         scount_reg <= '0;
      end else begin
         sv_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (search_en) begin
                  key_reg   <= search_din;
                  mask_reg  <= search_mask;
                  grp_reg   <= '0;
                  cnt_reg   <= '0;
                  found_reg <= 1'b0;
                  faddr_reg <= '0;
                  fdata_reg <= '0;
                  state_reg <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (hit_any && !found_reg) begin
                  found_reg <= 1'b1;
                  faddr_reg <= hit_addr;
                  fdata_reg <= hit_data;
               end
               cnt_reg <= cnt_reg + (AW + 1)'(hit_cnt);
               if (grp_reg == GW'(NGRP - 1))
                  state_reg <= ST_DONE;
               else
                  grp_reg <= grp_reg + GW'(1);
            end
            ST_DONE: begin
               sv_reg     <= 1'b1;
               sdout_reg  <= fdata_reg;
               saddr_reg  <= faddr_reg;
               scount_reg <= cnt_reg;
               snf_reg    <= (cnt_reg == '0);
               state_reg  <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign r_dout          = r_dout_reg;
   assign r_valid         = r_valid_reg;
   assign search_busy     = (state_reg != ST_IDLE);
   assign search_valid    = sv_reg;
   assign search_dout     = sdout_reg;
   assign search_addr_out = saddr_reg;
   assign search_notfound = snf_reg;
   assign search_count    = scount_reg;
endmodule

// File: tb/tb_ptcam_scan.sv
// Self-checking bench for ptcam_scan: directed scenarios plus randomized traffic,
// compared against a whole-table behavioural model of the CAM.
module tb_ptcam_scan;
   localparam int WIDTH = 19;
   localparam int DEPTH = 16;
   localparam int LANES = 4;
   localparam int AW    = 4;
   localparam logic [WIDTH-1:0] ALL1 = '1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             w_en = 1'b0, inv_en = 1'b0, clr_all = 1'b0, search_en = 1'b0;
   logic [AW-1:0]    w_addr = '0, inv_addr = '0, r_addr = '0;
   logic [WIDTH-1:0] w_din = '0, w_mask = '0, search_din = '0, search_mask = '0;
   logic [WIDTH-1:0] r_dout, search_dout;
   logic             r_valid, search_busy, search_valid, search_notfound;
   logic [AW-1:0]    search_addr_out;
   logic [AW:0]      search_count;

   always #5 clk = ~clk;

   ptcam_scan #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES)) dut (
      .clk(clk), .reset(reset),
      .w_en(w_en), .w_addr(w_addr), .w_din(w_din), .w_mask(w_mask),
      .inv_en(inv_en), .inv_addr(inv_addr), .clr_all(clr_all),
      .r_addr(r_addr), .r_dout(r_dout), .r_valid(r_valid),
      .search_en(search_en), .search_din(search_din), .search_mask(search_mask),
      .search_busy(search_busy), .search_valid(search_valid),
      .search_dout(search_dout), .search_addr_out(search_addr_out),
      .search_notfound(search_notfound), .search_count(search_count)
   );

   logic [WIDTH-1:0] m_mem [DEPTH];
   logic             m_valid [DEPTH];
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
   endtask

   // One cycle of table updates with the model applying the same priority rules.
   task automatic do_ops(input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                         input logic [WIDTH-1:0] wm, input logic ie, input logic [AW-1:0] ia,
                         input logic ca);
      logic [WIDTH-1:0] base;
      w_en = we; w_addr = wa; w_din = wd; w_mask = wm;
      inv_en = ie; inv_addr = ia; clr_all = ca;
      cycle();
      w_en = 1'b0; inv_en = 1'b0; clr_all = 1'b0;
      if (ca) begin
         model_clear();
      end else begin
         if (we && !(ie && ia == wa)) begin
            base = m_valid[wa] ? m_mem[wa] : '0;
            m_mem[wa]   = (base & ~wm) | (wd & wm);
            m_valid[wa] = 1'b1;
         end
         if (ie) m_valid[ia] = 1'b0;
      end
      $display("ops we=%0d wa=%0d wd=0x%0h wm=0x%0h ie=%0d ia=%0d clr=%0d", we, wa, wd, wm, ie, ia, ca);
   endtask

   task automatic do_search(input string tag, input logic [WIDTH-1:0] key, input logic [WIDTH-1:0] mask);
      int e_cnt = 0;
      int e_addr = 0;
      logic [WIDTH-1:0] e_dout = '0;
      int lat = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (m_valid[i] && ((m_mem[i] ^ key) & mask) == '0) begin
            if (e_cnt == 0) begin e_addr = i; e_dout = m_mem[i]; end
            e_cnt++;
         end
      end
      search_en = 1'b1; search_din = key; search_mask = mask;
      cycle();
      search_en = 1'b0;
      check({tag, ".busy"}, 32'(search_busy), 32'd1);
      for (int n = 1; n <= 8; n++) begin
         cycle();
         if (search_valid) begin lat = n; break; end
      end
      check({tag, ".lat"}, 32'(lat), 32'(DEPTH / LANES + 1));
      check({tag, ".nf"}, 32'(search_notfound), 32'(e_cnt == 0));
      check({tag, ".cnt"}, 32'(search_count), 32'(e_cnt));
      check({tag, ".addr"}, 32'(search_addr_out), 32'(e_addr));
      check({tag, ".dout"}, 32'(search_dout), 32'(e_dout));
      cycle();
      check({tag, ".pulse"}, 32'(search_valid), 32'd0);
      $display("search %s key=0x%0h mask=0x%0h -> addr=%0d dout=0x%0h cnt=%0d nf=%0d",
               tag, key, mask, search_addr_out, search_dout, search_count, search_notfound);
   endtask

   task automatic do_read(input string tag, input logic [AW-1:0] a);
      r_addr = a;
      cycle();
      check({tag, ".rv"}, 32'(r_valid), 32'(m_valid[a]));
      if (m_valid[a]) check({tag, ".rd"}, 32'(r_dout), 32'(m_mem[a]));
      $display("read %s addr=%0d -> dout=0x%0h valid=%0d", tag, a, r_dout, r_valid);
   endtask

   initial begin
      int pulses;
      logic [WIDTH-1:0] old_f;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      model_clear();

      repeat (3) cycle();
      reset = 1'b0;
      check("rst.sv", 32'(search_valid), 32'd0);
      check("rst.busy", 32'(search_busy), 32'd0);
      check("rst.nf", 32'(search_notfound), 32'd0);
      check("rst.cnt", 32'(search_count), 32'd0);
      check("rst.addr", 32'(search_addr_out), 32'd0);
      check("rst.dout", 32'(search_dout), 32'd0);
      check("rst.rv", 32'(r_valid), 32'd0);

      do_search("empty", '0, ALL1);
      check("empty.nf1", 32'(search_notfound), 32'd1);

      do_ops(1'b1, 4'd7, 19'hABC, ALL1, 1'b0, '0, 1'b0);
      do_ops(1'b1, 4'hF, 19'hDEF, ALL1, 1'b0, '0, 1'b0);
      do_search("abc", 19'hABC, ALL1);
      check("abc.addr7", 32'(search_addr_out), 32'd7);
      do_search("def", 19'hDEF, ALL1);
      check("def.addrF", 32'(search_addr_out), 32'hF);

      do_ops(1'b1, 4'd3, 19'h12C, ALL1, 1'b0, '0, 1'b0);
      do_search("nibC", 19'hC, 19'hF);
      check("nibC.cnt2", 32'(search_count), 32'd2);
      check("nibC.addr3", 32'(search_addr_out), 32'd3);

      // Read-during-write to F sees the old word, the next read the merged one.
      old_f = m_mem[15];
      r_addr = 4'hF;
      do_ops(1'b1, 4'hF, 19'h123, 19'h00F, 1'b0, '0, 1'b0);
      check("rdw.old", 32'(r_dout), 32'(old_f));
      cycle();
      check("rdw.new", 32'(r_dout), 32'h0DE3);
      check("rdw.rv", 32'(r_valid), 32'd1);

      do_ops(1'b0, '0, '0, '0, 1'b1, 4'd7, 1'b0);
      do_search("inv7", 19'hABC, ALL1);
      check("inv7.nf", 32'(search_notfound), 32'd1);

      // A second search_en while busy must be dropped.
      search_en = 1'b1; search_din = 19'hDE3; search_mask = ALL1;
      cycle();
      search_din = 19'h12C;
      cycle();
      search_en = 1'b0;
      pulses = 0;
      for (int n = 0; n < 12; n++) begin
         if (search_valid) begin
            pulses++;
            check("busy.addr", 32'(search_addr_out), 32'hF);
         end
         cycle();
      end
      check("busy.pulses", 32'(pulses), 32'd1);

      do_ops(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
      do_search("clr.a", 19'hDE3, ALL1);
      do_search("clr.b", 19'h0, 19'h0);
      check("clr.nf", 32'(search_notfound), 32'd1);

      // Reset during the second scan cycle aborts the search and clears the table.
      do_ops(1'b1, 4'd9, 19'h5A5A5, ALL1, 1'b0, '0, 1'b0);
      search_en = 1'b1; search_din = 19'h5A5A5; search_mask = ALL1;
      cycle();
      search_en = 1'b0;
      cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      model_clear();
      check("abort.rv", 32'(r_valid), 32'd0);
      pulses = 0;
      for (int n = 0; n < 8; n++) begin
         if (search_valid) pulses++;
         cycle();
      end
      check("abort.pulses", 32'(pulses), 32'd0);
      check("abort.busy", 32'(search_busy), 32'd0);
      check("abort.nf", 32'(search_notfound), 32'd0);
      check("abort.cnt", 32'(search_count), 32'd0);
      check("abort.dout", 32'(search_dout), 32'd0);
      do_search("abort.again", 19'h5A5A5, ALL1);
      check("abort.gone", 32'(search_notfound), 32'd1);

      for (int it = 0; it < 40; it++) begin
         logic [WIDTH-1:0] wd, wm, key, mask;
         wd   = WIDTH'($urandom_range(0, 15)) | ($urandom_range(0, 1) != 0 ? 19'h40000 : 19'h0);
         wm   = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom) : ALL1;
         do_ops($urandom_range(0, 3) != 0, AW'($urandom), wd, wm,
                $urandom_range(0, 4) == 0, AW'($urandom), $urandom_range(0, 24) == 0);
         do_read("rnd", AW'($urandom));
         if (it % 2 == 1) begin
            key  = m_mem[$urandom_range(0, DEPTH - 1)];
            mask = WIDTH'($urandom);
            if ($urandom_range(0, 1) != 0) mask = mask & 19'h0000F;
            do_search("rnd", key, mask);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
